// File: rtl/reg_write_sched_if.sv
// Commit, issue and register-file write-port bundle for reg_write_sched.
// Tag width follows `ROBSIZE from const.v; a fallback keeps this file standalone.
`ifndef ROBSIZE
`define ROBSIZE 4
`endif

interface reg_write_sched_if #(parameter int TAG_W = `ROBSIZE + 1);
  logic             commit_valid;
  logic             commit_ready;
  logic [4:0]       commit_reg;
  logic [31:0]      commit_val;
  logic [TAG_W-1:0] commit_rob;

  logic             issue_valid;
  logic             issue_ready;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] issue_rob;

  logic             need_set_reg_value;
  logic [4:0]       set_value_reg_id;
  logic [31:0]      set_val;
  logic [TAG_W-1:0] set_reg_rob_id;

  logic             need_set_reg_dep;
  logic [4:0]       set_dep_reg_id;
  logic [TAG_W-1:0] set_dep_rob_id;

  // master: ROB/decoder/register-file side; slave: the scheduler
  modport master (
    output commit_valid, commit_reg, commit_val, commit_rob,
    input  commit_ready,
    output issue_valid, issue_rd, issue_rob,
    input  issue_ready,
    input  need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
    input  need_set_reg_dep, set_dep_reg_id, set_dep_rob_id
  );

  modport slave (
    input  commit_valid, commit_reg, commit_val, commit_rob,
    output commit_ready,
    input  issue_valid, issue_rd, issue_rob,
    output issue_ready,
    output need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
    output need_set_reg_dep, set_dep_reg_id, set_dep_rob_id
  );
endinterface

// File: rtl/reg_write_sched.sv
// Register-file write-port scheduler: commit FIFO, rename pass-through, flush recovery.
// Optional REG_SCHED_BYPASS_EN: empty-FIFO commits go straight to the value port.
module reg_write_sched #(
  parameter int COMMIT_DEPTH = 4,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  reg_write_sched_if.slave    bus,
  output logic                clear,
  output logic                busy
);
  localparam int TAG_W = `ROBSIZE + 1;
  localparam int PTR_W = (COMMIT_DEPTH > 1) ? $clog2(COMMIT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, HOLD} state_t;

  state_t           state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic [3:0]       hold_cnt;

  logic [4:0]       fifo_reg [COMMIT_DEPTH];
  logic [31:0]      fifo_val [COMMIT_DEPTH];
  logic [TAG_W-1:0] fifo_rob [COMMIT_DEPTH];

  logic run;
  logic commit_keep;
  logic issue_acc;
  logic pop;
  logic bypass;
  logic push;

  assign run              = (state == RUN);
  assign bus.commit_ready = rdy && run && (count < CNT_W'(COMMIT_DEPTH));
  assign bus.issue_ready  = rdy && run && !flush;
  assign commit_keep      = bus.commit_valid && bus.commit_ready && (bus.commit_reg != 5'd0);
  assign issue_acc        = bus.issue_valid && bus.issue_ready;
  assign pop              = rdy && (count != '0) && (state == RUN || state == DRAIN);

`ifdef REG_SCHED_BYPASS_EN
  // commit_ready already implies rdy and RUN, so only the empty check remains
  assign bypass = commit_keep && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push       = commit_keep && !bypass;
  assign next_count = count + CNT_W'(push) - CNT_W'(pop);
  assign clear      = rdy && (state == CLEAR);
  assign busy       = !run;

  always_comb begin
    bus.need_set_reg_value = 1'b0;
    bus.set_value_reg_id   = '0;
    bus.set_val            = '0;
    bus.set_reg_rob_id     = '0;
    if (pop) begin
      bus.need_set_reg_value = 1'b1;
      bus.set_value_reg_id   = fifo_reg[head];
      bus.set_val            = fifo_val[head];
      bus.set_reg_rob_id     = fifo_rob[head];
    end else if (bypass) begin
      bus.need_set_reg_value = 1'b1;
      bus.set_value_reg_id   = bus.commit_reg;
      bus.set_val            = bus.commit_val;
      bus.set_reg_rob_id     = bus.commit_rob;
    end
  end

  always_comb begin
    bus.need_set_reg_dep = 1'b0;
    bus.set_dep_reg_id   = '0;
    bus.set_dep_rob_id   = '0;
    if (issue_acc && bus.issue_rd != 5'd0) begin
      bus.need_set_reg_dep = 1'b1;
      bus.set_dep_reg_id   = bus.issue_rd;
      bus.set_dep_rob_id   = bus.issue_rob;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[tail] <= bus.commit_reg;
      fifo_val[tail] <= bus.commit_val;
      fifo_rob[tail] <= bus.commit_rob;
    end
  end

  // Flush decides DRAIN vs CLEAR on the post-edge count so a same-cycle commit is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      hold_cnt <= '0;
    end else if (rdy) begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= next_count;
      unique case (state)
        RUN:   if (flush) state <= (next_count != '0) ? DRAIN : CLEAR;
        DRAIN: if (next_count == '0) state <= CLEAR;
        CLEAR: begin
          if (HOLD_CYCLES == 0) begin
            state <= RUN;
          end else begin
            state    <= HOLD;
            hold_cnt <= 4'(HOLD_CYCLES);
          end
        end
        HOLD: begin
          if (hold_cnt <= 4'd1) begin
            state    <= RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_write_sched.sv
// Self-checking bench for reg_write_sched: directed vector table, hand sequences,
// then randomized traffic against a queue-and-timeline reference model.
`ifndef ROBSIZE
`define ROBSIZE 4
`endif

module tb_reg_write_sched;
  localparam int TAG_W = `ROBSIZE + 1;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  logic clear;
  logic busy;

  reg_write_sched_if #(.TAG_W(TAG_W)) bus ();

  reg_write_sched #(.COMMIT_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .bus(bus), .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic             rdy, flush, cv;
    logic [4:0]       creg;
    logic [31:0]      cval;
    logic [TAG_W-1:0] crob;
    logic             iv;
    logic [4:0]       ird;
    logic [TAG_W-1:0] irob;
    logic [3:0]       e_hs;
    logic             e_nsv;
    logic [4:0]       e_sreg;
    logic [31:0]      e_sval;
    logic [TAG_W-1:0] e_srob;
    logic             e_nsd;
    logic [4:0]       e_dreg;
    logic [TAG_W-1:0] e_drob;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [4:0]       r;
    logic [31:0]      v;
    logic [TAG_W-1:0] rb;
  } ent_t;

  ent_t q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic fl, input logic cv, input logic [4:0] creg,
                               input logic [31:0] cval, input logic [TAG_W-1:0] crob,
                               input logic iv, input logic [4:0] ird, input logic [TAG_W-1:0] irob);
    rdy              = r;
    flush            = fl;
    bus.commit_valid = cv;
    bus.commit_reg   = creg;
    bus.commit_val   = cval;
    bus.commit_rob   = crob;
    bus.issue_valid  = iv;
    bus.issue_rd     = ird;
    bus.issue_rob    = irob;
  endtask

  task automatic addVec(input logic r, input logic fl, input logic cv, input logic [4:0] creg,
                        input logic [31:0] cval, input logic [TAG_W-1:0] crob,
                        input logic iv, input logic [4:0] ird, input logic [TAG_W-1:0] irob,
                        input logic [3:0] hs, input logic nsv, input logic [4:0] sreg,
                        input logic [31:0] sval, input logic [TAG_W-1:0] srob,
                        input logic nsd, input logic [4:0] dreg, input logic [TAG_W-1:0] drob);
    vec_t v;
    v.rdy = r; v.flush = fl; v.cv = cv; v.creg = creg; v.cval = cval; v.crob = crob;
    v.iv = iv; v.ird = ird; v.irob = irob; v.e_hs = hs;
    v.e_nsv = nsv; v.e_sreg = sreg; v.e_sval = sval; v.e_srob = srob;
    v.e_nsd = nsd; v.e_dreg = dreg; v.e_drob = drob;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] packVal(input logic s, input logic [4:0] r,
                                          input logic [31:0] v, input logic [TAG_W-1:0] rb);
    return s ? 64'({1'b1, r, v, rb}) : 64'd0;
  endfunction

  function automatic logic [63:0] packDep(input logic s, input logic [4:0] r, input logic [TAG_W-1:0] rb);
    return s ? 64'({1'b1, r, rb}) : 64'd0;
  endfunction

  function automatic logic [63:0] hsAct();
    return 64'({bus.commit_ready, bus.issue_ready, clear, busy});
  endfunction

  function automatic logic [63:0] valAct();
    return packVal(bus.need_set_reg_value, bus.set_value_reg_id, bus.set_val, bus.set_reg_rob_id);
  endfunction

  function automatic logic [63:0] depAct();
    return packDep(bus.need_set_reg_dep, bus.set_dep_reg_id, bus.set_dep_rob_id);
  endfunction

  function automatic logic [63:0] rawAll();
    return 64'({bus.commit_ready, bus.issue_ready, clear, busy,
                bus.need_set_reg_value, bus.set_value_reg_id, bus.set_val, bus.set_reg_rob_id,
                bus.need_set_reg_dep, bus.set_dep_reg_id, bus.set_dep_rob_id});
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("reset_outputs", rawAll(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

`ifndef REG_SCHED_BYPASS_EN
    // rdy flush cv creg cval crob iv ird irob | hs{cr,ir,clr,busy} nsv sreg sval srob nsd dreg drob
    addVec(1,0,1, 5,32'hDEADBEEF,3, 0,0,0, 4'b1100, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b1100, 1, 5,32'hDEADBEEF,3,  0,0,0);
    addVec(1,0,1, 7,32'h11,1,       0,0,0, 4'b1100, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,1, 0,32'h22,4,       1,7,2, 4'b1100, 1, 7,32'h11,1,        1,7,2);
    addVec(1,0,0, 0,32'h0,0,        1,0,5, 4'b1100, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,1, 9,32'hA5,6,       0,0,0, 4'b1100, 0, 0,32'h0,0,         0,0,0);
    addVec(1,1,1,10,32'hB0,7,       1,3,1, 4'b1000, 1, 9,32'hA5,6,        0,0,0);
    addVec(0,0,1,11,32'h33,8,       0,0,0, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(0,1,0, 0,32'h0,0,        0,0,0, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(0,0,0, 0,32'h0,0,        0,0,0, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(1,1,1,11,32'h33,8,       1,4,2, 4'b0001, 1,10,32'hB0,7,        0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b0011, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        1,6,9, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        1,6,9, 4'b1100, 0, 0,32'h0,0,         1,6,9);
    addVec(1,1,0, 0,32'h0,0,        0,0,0, 4'b1000, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b0011, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b0001, 0, 0,32'h0,0,         0,0,0);
    addVec(1,0,0, 0,32'h0,0,        0,0,0, 4'b1100, 0, 0,32'h0,0,         0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].rdy, vecs[i].flush, vecs[i].cv, vecs[i].creg, vecs[i].cval,
                    vecs[i].crob, vecs[i].iv, vecs[i].ird, vecs[i].irob);
      #1;
      checkOutput($sformatf("vec%0d_hs", i), hsAct(), 64'(vecs[i].e_hs));
      checkOutput($sformatf("vec%0d_val", i), valAct(),
                  packVal(vecs[i].e_nsv, vecs[i].e_sreg, vecs[i].e_sval, vecs[i].e_srob));
      checkOutput($sformatf("vec%0d_dep", i), depAct(),
                  packDep(vecs[i].e_nsd, vecs[i].e_dreg, vecs[i].e_drob));
    end
`endif

    // Empty-FIFO flush, then reset while in HOLD
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("flush_empty_hs", hsAct(), 64'(4'b1000));
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("clear_pulse_hs", hsAct(), 64'(4'b0011));
    @(negedge clk);
    #1 checkOutput("hold_hs", hsAct(), 64'(4'b0001));
    @(negedge clk);
    rdy = 1'b0;
    rst = 1'b1;
    #1 checkOutput("rst_in_hold", rawAll(), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 checkOutput("rdy_low_after_rst", hsAct(), 64'd0);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 3, 4);
    #1;
    checkOutput("run_after_rst_hs", hsAct(), 64'(4'b1100));
    checkOutput("run_after_rst_dep", depAct(), packDep(1, 3, 4));

    // Randomized traffic against a queue plus active-cycle timeline model
    begin
      bit recov = 0;
      int act = 0;
      int f_act = 0;
      int k = 0;
      for (int c = 0; c < 600; c++) begin
        logic r, fl, cv, iv, run_m, cr, ir, clr, bsy, vs, from_q, nsd;
        logic [4:0] creg, ird;
        logic [31:0] cval;
        logic [TAG_W-1:0] crob, irob;
        ent_t e;
        @(negedge clk);
        r    = ($urandom_range(0, 7) != 0);
        fl   = ($urandom_range(0, 11) == 0);
        cv   = ($urandom_range(0, 9) < 7);
        creg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cval = $urandom;
        crob = TAG_W'($urandom);
        iv   = $urandom_range(0, 1) != 0;
        ird  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        irob = TAG_W'($urandom);
        applyStimulus(r, fl, cv, creg, cval, crob, iv, ird, irob);
        #1;
        if (recov && act >= f_act + k + 2 + HOLD) recov = 0;
        run_m  = !recov;
        cr     = r && run_m && (q.size() < DEPTH);
        ir     = r && run_m && !fl;
        clr    = r && recov && (act == f_act + k + 1);
        bsy    = recov;
        from_q = r && (q.size() > 0);
        vs     = from_q;
        e      = '{r: 5'd0, v: 32'd0, rb: '0};
        if (from_q) e = q[0];
`ifdef REG_SCHED_BYPASS_EN
        if (!from_q && cr && cv && creg != 5'd0) begin
          vs = 1'b1;
          e  = '{r: creg, v: cval, rb: crob};
        end
`endif
        nsd = ir && iv && (ird != 5'd0);
        checkOutput($sformatf("rand%0d_hs", c), hsAct(), 64'({cr, ir, clr, bsy}));
        checkOutput($sformatf("rand%0d_val", c), valAct(), packVal(vs, e.r, e.v, e.rb));
        checkOutput($sformatf("rand%0d_dep", c), depAct(), packDep(nsd, ird, irob));
        if (r) begin
          if (from_q) void'(q.pop_front());
          if (cr && cv && creg != 5'd0 && !(vs && !from_q))
            q.push_back('{r: creg, v: cval, rb: crob});
          if (fl && run_m) begin
            recov = 1;
            f_act = act;
            k     = q.size();
          end
          act++;
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
